// File: rtl/branch_predictor.sv
// Fetch-side direct-mapped BTB with 2-bit counters, plus EX-stage mispredict
// detection, redirect generation and table training.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    // EX side is valid-only: ex_valid qualifies every ex_* input for exactly
    // one cycle and there is no ready; the unit accepts a resolve every cycle.

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];

    logic [IDXW-1:0] if_idx;
    logic [IDXW-1:0] ex_idx;
    logic [TAGW-1:0] if_tag;
    logic [TAGW-1:0] ex_tag;
    logic            if_hit;
    logic            ex_hit;
    logic            mis;
    logic            ex_live;
    logic [XLEN-1:0] if_pc_plus4;
    logic [XLEN-1:0] ex_pc_plus4;

    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;
    logic [31:0] branch_cnt_d;
    logic [31:0] mispred_cnt_d;

    assign if_idx      = if_pc[IDXW+1:2];
    assign if_tag      = if_pc[XLEN-1:IDXW+2];
    assign ex_idx      = ex_pc[IDXW+1:2];
    assign ex_tag      = ex_pc[XLEN-1:IDXW+2];
    assign if_pc_plus4 = if_pc + XLEN'(4);
    assign ex_pc_plus4 = ex_pc + XLEN'(4);

    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_live = ex_valid && !reset;

    // Lookup reads only the registered table, so a same-cycle update to the
    // same index is not visible until the following cycle.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = if_pc_plus4;
        if (!reset && if_valid && if_hit && ctr_q[if_idx][1]) begin
            pred_taken  = 1'b1;
            pred_target = target_q[if_idx];
        end
    end

    assign mis = ex_live &&
                 ((ex_taken != ex_pred_taken) ||
                  (ex_taken && (ex_pred_target != ex_target)));

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        if (mis) begin
            redirect    = 1'b1;
            redirect_pc = ex_taken ? ex_target : ex_pc_plus4;
        end
    end

    assign flush = redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (ex_valid) begin
            if (ex_hit) begin
                if (ex_taken) begin
                    ctr_q[ex_idx]    <= (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
                    target_q[ex_idx] <= ex_target;
                end else begin
                    ctr_q[ex_idx] <= (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
                end
            end else if (ex_taken) begin
                // A taken miss claims the slot even if another branch aliases it.
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                ctr_q[ex_idx]    <= 2'b10;
            end
        end
    end

    assign branch_cnt_d  = branch_cnt_q + {31'b0, ex_live};
    assign mispred_cnt_d = mispred_cnt_q + {31'b0, mis};

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: cycle table of inputs and expected outputs,
// random cold-table lookups, and a statistics wrap sequence.
module tb_branch_predictor;

    localparam int XLEN = 32;
    localparam int EW   = 1 + 32 + 1 + 32 + 1 + 32 + 32;
    localparam int NV   = 24;

    logic            clk;
    logic            reset;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic [31:0]     branch_cnt;
    logic [31:0]     mispred_cnt;

    int checks;
    int failures;

    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        ifv;
        logic [31:0] ifpc;
        logic        exv;
        logic [31:0] expc;
        logic        ext;
        logic [31:0] extgt;
        logic        exppt;
        logic [31:0] exptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_red;
        logic [31:0] e_rpc;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t tbl[NV];

    branch_predictor #(.ENTRIES(16), .XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_target(ex_pred_target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        reset          = v.rst;
        if_valid       = v.ifv;
        if_pc          = v.ifpc;
        ex_valid       = v.exv;
        ex_pc          = v.expc;
        ex_taken       = v.ext;
        ex_target      = v.extgt;
        ex_pred_taken  = v.exppt;
        ex_pred_target = v.exptgt;
    endtask

    // Drive on the falling edge, queue the expectation, sample 2 ns later.
    task automatic apply(input vec_t v, input string name);
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        @(negedge clk);
        drive(v);
        exp_q.push_back({v.e_pt, v.e_ptgt, v.e_red, v.e_rpc, v.e_red, v.e_bc, v.e_mc});
        #2;
        got = {pred_taken, pred_target, redirect, redirect_pc, flush, branch_cnt, mispred_cnt};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got pt=%0b ptgt=%h red=%0b rpc=%h fl=%0b bc=%0d mc=%0d exp pt=%0b ptgt=%h red=%0b rpc=%h fl=%0b bc=%0d mc=%0d",
                     name, got[130], got[129:98], got[97], got[96:65], got[64], got[63:32], got[31:0],
                     exp[130], exp[129:98], exp[97], exp[96:65], exp[64], exp[63:32], exp[31:0]);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        vec_t r;
        checks   = 0;
        failures = 0;

        // rst ifv ifpc exv expc ext extgt exppt exptgt | pt ptgt red rpc bc mc
        tbl[0]  = '{1, 1, 32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 0, 32'h0,   0,  0};
        tbl[1]  = '{1, 1, 32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 0, 32'h0,   0,  0};
        tbl[2]  = '{0, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0,   0,  0};
        tbl[3]  = '{0, 1, 32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  0,  0};
        tbl[4]  = '{0, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h0,   1,  1};
        tbl[5]  = '{0, 1, 32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h80,  1, 32'h80,  1, 32'h104, 1,  1};
        tbl[6]  = '{0, 1, 32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h104, 0, 32'h104, 0, 32'h0,   2,  2};
        tbl[7]  = '{0, 1, 32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  3,  2};
        tbl[8]  = '{0, 1, 32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  4,  3};
        tbl[9]  = '{0, 1, 32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h0,   5,  4};
        tbl[10] = '{0, 1, 32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h0,   6,  4};
        tbl[11] = '{0, 1, 32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h80,  1, 32'h80,  1, 32'h104, 7,  4};
        tbl[12] = '{0, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h0,   8,  5};
        tbl[13] = '{0, 1, 32'h100, 1, 32'h100, 1, 32'h90,  1, 32'h80,  1, 32'h80,  1, 32'h90,  8,  5};
        tbl[14] = '{0, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h90,  0, 32'h0,   9,  6};
        tbl[15] = '{0, 1, 32'h100, 1, 32'h140, 1, 32'h200, 0, 32'h144, 1, 32'h90,  1, 32'h200, 9,  6};
        tbl[16] = '{0, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0,   10, 7};
        tbl[17] = '{0, 1, 32'h140, 1, 32'h100, 0, 32'h0,   0, 32'h104, 1, 32'h200, 0, 32'h0,   10, 7};
        tbl[18] = '{0, 1, 32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h0,   11, 7};
        tbl[19] = '{0, 0, 32'h140, 1, 32'h300, 0, 32'h0,   0, 32'h999, 0, 32'h144, 0, 32'h0,   11, 7};
        tbl[20] = '{0, 1, 32'h142, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h0,   12, 7};
        tbl[21] = '{0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0, 0, 32'h0, 1, 32'h0, 12, 7};
        tbl[22] = '{1, 1, 32'h140, 1, 32'h140, 0, 32'h0,   1, 32'h200, 0, 32'h144, 0, 32'h0,   13, 8};
        tbl[23] = '{0, 1, 32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h144, 0, 32'h0,   0,  0};

        // Unchecked first reset cycle so registers are defined before sampling.
        r = tbl[0];
        drive(r);
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // Random lookups into the freshly reset (empty) table.
        for (int i = 0; i < 8; i++) begin
            r        = tbl[23];
            r.ifv    = 1'($urandom_range(0, 1));
            r.ifpc   = $urandom;
            r.e_pt   = 1'b0;
            r.e_ptgt = r.ifpc + 32'd4;
            apply(r, $sformatf("cold%0d", i));
        end

        // Statistics wrap: preload both counters with all-ones, then one mispredict.
        @(negedge clk);
        ex_valid = 1'b0;
        force dut.branch_cnt_d  = 32'hFFFF_FFFF;
        force dut.mispred_cnt_d = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.branch_cnt_d;
        release dut.mispred_cnt_d;
        #1;
        check32("bc_preload", branch_cnt, 32'hFFFF_FFFF);
        check32("mc_preload", mispred_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        ex_valid       = 1'b1;
        ex_pc          = 32'h500;
        ex_taken       = 1'b1;
        ex_target      = 32'h400;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'h504;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        check32("bc_wrap", branch_cnt, 32'h0);
        check32("mc_wrap", mispred_cnt, 32'h0);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
